// File: rtl/ulaplus_palette_if.sv
// Bus bundle between the video/CPU side and the ULAplus palette stage.
// The master drives palette writes and pixel requests; the slave returns
// colour results and the clear-sweep status.
interface ulaplus_palette_if;
    logic       active;
    logic       write_req;
    logic [5:0] write_addr;
    logic [7:0] write_data;
    logic       pix_valid;
    logic       pix_ink;
    logic       pix_border;
    logic [7:0] pix_attr;
    logic [2:0] border_color;
    logic       busy;
    logic       rgb_valid;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;

    modport master (
        output active, write_req, write_addr, write_data,
        output pix_valid, pix_ink, pix_border, pix_attr, border_color,
        input  busy, rgb_valid, r, g, b
    );

    modport slave (
        input  active, write_req, write_addr, write_data,
        input  pix_valid, pix_ink, pix_border, pix_attr, border_color,
        output busy, rgb_valid, r, g, b
    );
endinterface

// File: rtl/ulaplus_palette.sv
// ULAplus palette storage and colour lookup.
// 64-entry GGGRRRBB palette written by the port decoder, a two-stage
// lookup pipeline (index/read, then colour expansion) and an optional
// post-reset clear sweep. With ULAplus inactive the standard ZX colours
// are produced instead, so the DAC path sees the same 9-bit RGB format.
module ulaplus_palette #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk28,
    input  logic               rst,
    ulaplus_palette_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Standard ZX channel level: off, normal (5/7) or bright (full).
    function automatic logic [2:0] zx_chan(input logic on, input logic bright);
        logic [2:0] lvl;
        if (on) begin
            if (bright) begin
                lvl = 3'b111;
            end else begin
                lvl = 3'b101;
            end
        end else begin
            lvl = 3'b000;
        end
        return lvl;
    endfunction

    // Two-bit palette blue widened to three bits; LSB is the OR of both.
    function automatic logic [2:0] pal_blue(input logic [1:0] bb);
        return {bb[1], bb[0], bb[1] | bb[0]};
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;
    logic       clear_we_s;
    logic       cpu_we_s;

    logic [7:0] pal_r [0:63];

    logic [5:0] idx_s;
    logic [2:0] code_s;
    logic       bright_s;
    logic [7:0] entry_s;
    logic [8:0] zx_rgb_s;

    logic       s1_valid_r;
    logic       s1_active_r;
    logic       s1_blank_r;
    logic [7:0] s1_entry_r;
    logic [8:0] s1_zx_r;

    logic [8:0] out_rgb_s;
    logic       rgb_valid_r;
    logic [2:0] r_r;
    logic [2:0] g_r;
    logic [2:0] b_r;

    // Clear-sweep FSM: next state, sweep counter and palette write enables.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        clear_we_s  = 1'b0;
        cpu_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cpu_we_s = bus.write_req;
            end
            ST_CLEAR: begin
                clear_we_s = 1'b1;
                cnt_nxt_s  = cnt_r + 6'd1;
                if (cnt_r == 6'd63) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_CLEAR);
    end

    // Clear-sweep FSM state, counter and registered busy flag.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_r   <= 6'd0;
            busy_r  <= CLEAR_ON_RESET;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Palette storage: the sweep has priority; CPU writes are dropped while it runs.
    always_ff @(posedge clk28) begin
        if (!rst) begin
            if (clear_we_s) begin
                pal_r[cnt_r] <= 8'h00;
            end else if (cpu_we_s) begin
                pal_r[bus.write_addr] <= bus.write_data;
            end
        end
    end

    // Stage-1 index, ZX colour code and brightness for the presented pixel.
    always_comb begin
        idx_s    = 6'd0;
        code_s   = 3'd0;
        bright_s = 1'b0;
        if (bus.pix_border) begin
            idx_s    = {2'b00, 1'b1, bus.border_color};
            code_s   = bus.border_color;
            bright_s = 1'b0;
        end else if (bus.pix_ink) begin
            idx_s    = {bus.pix_attr[7:6], 1'b0, bus.pix_attr[2:0]};
            code_s   = bus.pix_attr[2:0];
            bright_s = bus.pix_attr[6];
        end else begin
            idx_s    = {bus.pix_attr[7:6], 1'b1, bus.pix_attr[5:3]};
            code_s   = bus.pix_attr[5:3];
            bright_s = bus.pix_attr[6];
        end
    end

    // Palette read with bypass of a CPU write to the same entry on this edge.
    always_comb begin
        entry_s = 8'h00;
        if (cpu_we_s && (bus.write_addr == idx_s)) begin
            entry_s = bus.write_data;
        end else begin
            entry_s = pal_r[idx_s];
        end
        // GRB code bits map to G=[2], R=[1], B=[0]; output packing is {r,g,b}.
        zx_rgb_s = {zx_chan(code_s[1], bright_s),
                    zx_chan(code_s[2], bright_s),
                    zx_chan(code_s[0], bright_s)};
    end

    // Stage-1 registers: entry, ZX fallback, mode and blanking captured with the pixel.
    always_ff @(posedge clk28) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_active_r <= 1'b0;
            s1_blank_r  <= 1'b0;
            s1_entry_r  <= 8'h00;
            s1_zx_r     <= 9'd0;
        end else begin
            s1_valid_r  <= bus.pix_valid;
            s1_active_r <= bus.active;
            s1_blank_r  <= (state_r == ST_CLEAR);
            s1_entry_r  <= entry_s;
            s1_zx_r     <= zx_rgb_s;
        end
    end

    // Stage-2 colour select: blank during the sweep, palette or ZX otherwise.
    always_comb begin
        out_rgb_s = 9'd0;
        if (s1_blank_r) begin
            out_rgb_s = 9'd0;
        end else if (s1_active_r) begin
            out_rgb_s = {s1_entry_r[4:2], s1_entry_r[7:5], pal_blue(s1_entry_r[1:0])};
        end else begin
            out_rgb_s = s1_zx_r;
        end
    end

    // Stage-2 output registers; colour holds while no pixel is emerging.
    always_ff @(posedge clk28) begin
        if (rst) begin
            rgb_valid_r <= 1'b0;
            r_r         <= 3'd0;
            g_r         <= 3'd0;
            b_r         <= 3'd0;
        end else begin
            rgb_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                {r_r, g_r, b_r} <= out_rgb_s;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.rgb_valid = rgb_valid_r;
    assign bus.r         = r_r;
    assign bus.g         = g_r;
    assign bus.b         = b_r;

endmodule

// File: tb/tb_ulaplus_palette.sv
// Self-checking bench for ulaplus_palette: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_ulaplus_palette;

    logic clk28 = 1'b0;
    logic rst   = 1'b1;

    ulaplus_palette_if bus ();

    ulaplus_palette #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk28 = ~clk28;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state: palette contents, sweep progress, two pipeline slots.
    logic [7:0] m_pal [64];
    logic       m_busy = 1'b0;
    int         m_cnt  = 0;
    logic       m_v1   = 1'b0;
    logic [8:0] m_c1   = 9'd0;
    logic       m_vo   = 1'b0;
    logic [8:0] m_co   = 9'd0;

    typedef struct {
        logic       we;
        logic [5:0] wa;
        logic [7:0] wd;
        logic       act;
        logic       brd;
        logic       ink;
        logic [7:0] attr;
        logic [2:0] bc;
        logic [8:0] exp_rgb;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour of the currently presented pixel, from the palette/ZX rules.
    function automatic logic [8:0] ref_colour();
        int         idx;
        logic [2:0] c;
        logic       br;
        logic [7:0] e;
        logic [2:0] lv;
        logic [2:0] bl;
        if (bus.pix_border) begin
            c   = bus.border_color;
            idx = 8 + int'(c);
            br  = 1'b0;
        end else begin
            c   = bus.pix_ink ? bus.pix_attr[2:0] : bus.pix_attr[5:3];
            idx = int'(bus.pix_attr[7:6]) * 16 + (bus.pix_ink ? 0 : 8) + int'(c);
            br  = bus.pix_attr[6];
        end
        if (bus.active) begin
            e = m_pal[idx];
            case (e[1:0])
                2'd0:    bl = 3'd0;
                2'd1:    bl = 3'd3;
                2'd2:    bl = 3'd5;
                default: bl = 3'd7;
            endcase
            return {e[4:2], e[7:5], bl};
        end
        lv = br ? 3'd7 : 3'd5;
        return {c[1] ? lv : 3'd0, c[2] ? lv : 3'd0, c[0] ? lv : 3'd0};
    endfunction

    // Effect of one clock edge on the model, given the inputs now presented.
    task automatic model_edge();
        logic was_busy;
        if (rst) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_v1   = 1'b0;
            m_vo   = 1'b0;
            m_co   = 9'd0;
        end else begin
            was_busy = m_busy;
            if (was_busy) m_pal[m_cnt] = 8'h00;
            else if (bus.write_req) m_pal[bus.write_addr] = bus.write_data;
            m_vo = m_v1;
            if (m_v1) m_co = m_c1;
            m_v1 = bus.pix_valid;
            m_c1 = was_busy ? 9'd0 : ref_colour();
            if (was_busy) begin
                m_cnt++;
                if (m_cnt == 64) m_busy = 1'b0;
            end
        end
    endtask

    // One clock: advance model, let the DUT clock, compare just after the edge.
    task automatic step();
        model_edge();
        @(posedge clk28);
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("rgb_valid", 32'(bus.rgb_valid), 32'(m_vo));
        check("rgb", 32'({bus.r, bus.g, bus.b}), 32'(m_co));
    endtask

    task automatic idle_inputs();
        bus.write_req  = 1'b0;
        bus.write_addr = 6'd0;
        bus.write_data = 8'h00;
        bus.pix_valid  = 1'b0;
        bus.pix_ink    = 1'b0;
        bus.pix_border = 1'b0;
        bus.pix_attr   = 8'h00;
        bus.border_color = 3'd0;
    endtask

    task automatic set_pixel(input logic act, input logic brd, input logic ink,
                             input logic [7:0] attr, input logic [2:0] bc);
        bus.active       = act;
        bus.pix_valid    = 1'b1;
        bus.pix_border   = brd;
        bus.pix_ink      = ink;
        bus.pix_attr     = attr;
        bus.border_color = bc;
    endtask

    initial begin
        int         n;
        int         run;
        int         max_run;
        int         total;
        logic [5:0] ix;
        logic       acts [5];

        for (int i = 0; i < 64; i++) m_pal[i] = 8'h00;

        tbl[0] = '{1'b1, 6'd17, 8'hE3, 1'b1, 1'b0, 1'b1, 8'h41, 3'd0, {3'b000, 3'b111, 3'b111}};
        tbl[1] = '{1'b1, 6'd8,  8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, {3'b111, 3'b000, 3'b000}};
        tbl[2] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h50, 3'd0, {3'b111, 3'b000, 3'b000}};
        tbl[3] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0, {3'b101, 3'b000, 3'b000}};
        tbl[4] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h47, 3'd0, {3'b111, 3'b111, 3'b111}};
        tbl[5] = '{1'b0, 6'd0,  8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 3'd6, {3'b101, 3'b101, 3'b000}};
        tbl[6] = '{1'b1, 6'd63, 8'h49, 1'b1, 1'b0, 1'b0, 8'hF8, 3'd0, {3'b010, 3'b010, 3'b011}};

        idle_inputs();
        bus.active = 1'b0;

        // Reset state.
        rst = 1'b1;
        step();
        step();
        check("reset_busy", 32'(bus.busy), 32'd1);
        check("reset_valid", 32'(bus.rgb_valid), 32'd0);
        check("reset_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);

        // Sweep length, with a CPU write at sweep cycle 10 that must be lost.
        rst = 1'b0;
        n = 0;
        while (1) begin
            if (n == 10) begin
                bus.write_req  = 1'b1;
                bus.write_addr = 6'd17;
                bus.write_data = 8'hFF;
            end else begin
                bus.write_req  = 1'b0;
            end
            step();
            n++;
            if (!bus.busy || n > 200) break;
        end
        check("sweep_len", 32'(n), 32'd64);
        idle_inputs();

        // Every palette index reads back as zero after the sweep.
        for (int i = 0; i < 65; i++) begin
            if (i < 64) begin
                ix = 6'(i);
                if (ix[3]) set_pixel(1'b1, 1'b0, 1'b0, {ix[5:4], ix[2:0], 3'b000}, 3'd0);
                else       set_pixel(1'b1, 1'b0, 1'b1, {ix[5:4], 3'b000, ix[2:0]}, 3'd0);
            end else begin
                idle_inputs();
            end
            step();
            if (i >= 1) check("swept_zero", 32'({bus.rgb_valid, bus.r, bus.g, bus.b}), 32'h200);
        end
        idle_inputs();
        step();

        // Directed vector table: optional write, pixel, result after two edges, then hold.
        for (int i = 0; i < 7; i++) begin
            bus.write_req  = tbl[i].we;
            bus.write_addr = tbl[i].wa;
            bus.write_data = tbl[i].wd;
            step();
            bus.write_req = 1'b0;
            set_pixel(tbl[i].act, tbl[i].brd, tbl[i].ink, tbl[i].attr, tbl[i].bc);
            step();
            idle_inputs();
            step();
            check("vec_valid", 32'(bus.rgb_valid), 32'd1);
            check("vec_rgb", 32'({bus.r, bus.g, bus.b}), 32'(tbl[i].exp_rgb));
            step();
            check("vec_drop", 32'(bus.rgb_valid), 32'd0);
            check("vec_hold", 32'({bus.r, bus.g, bus.b}), 32'(tbl[i].exp_rgb));
        end

        // Read-during-write bypass on entry 5.
        bus.write_req  = 1'b1;
        bus.write_addr = 6'd5;
        bus.write_data = 8'h02;
        set_pixel(1'b1, 1'b0, 1'b1, 8'h05, 3'd0);
        step();
        idle_inputs();
        step();
        check("bypass", 32'({bus.rgb_valid, bus.r, bus.g, bus.b}), 32'({1'b1, 3'b000, 3'b000, 3'b101}));

        // Five back-to-back pixels with the mode toggling mid-burst.
        acts = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run = 0; max_run = 0; total = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) set_pixel(acts[i], 1'b0, 1'(i % 2), 8'h41 + 8'(i), 3'd0);
            else idle_inputs();
            step();
            if (bus.rgb_valid) begin
                run++;
                total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("burst_total", 32'(total), 32'd5);
        check("burst_run", 32'(max_run), 32'd5);

        // Reset in the middle of a burst clears the output strobe next cycle.
        for (int i = 0; i < 3; i++) begin
            set_pixel(1'b0, 1'b0, 1'b1, 8'h07, 3'd0);
            step();
        end
        rst = 1'b1;
        step();
        check("rst_midburst_valid", 32'(bus.rgb_valid), 32'd0);
        rst = 1'b0;
        idle_inputs();

        // Reset mid-sweep restarts the full 64-cycle sweep.
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (n == 20 && k < 25) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                n = 0;
            end else begin
                step();
                n++;
                if (!bus.busy) break;
            end
        end
        check("resweep_len", 32'(n), 32'd64);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 999) == 0);
            bus.write_req  = ($urandom_range(0, 2) == 0);
            bus.write_addr = 6'($urandom);
            bus.write_data = 8'($urandom);
            bus.pix_valid  = ($urandom_range(0, 3) != 0);
            bus.pix_border = ($urandom_range(0, 4) == 0);
            bus.pix_ink    = 1'($urandom);
            bus.pix_attr   = 8'($urandom);
            bus.border_color = 3'($urandom);
            if ($urandom_range(0, 7) == 0) bus.active = ~bus.active;
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ulaplus_palette.md
Name: ulaplus_palette

Overview:
Palette storage and colour lookup stage, downstream of the ULAplus port decoder. It consumes that decoder's palette write requests (6-bit address, CPU data byte) into a 64-entry GGGRRRBB palette. It converts the video pipeline's per-pixel attribute/ink/border information into 9-bit RGB with a fixed 2-cycle latency. When ULAplus is inactive it emits standard ZX colours, so the downstream DAC path is unchanged.

Parameters:
CLEAR_ON_RESET, 1, when 1 the palette is swept to 8'h00 after reset; when 0 the palette contents are undefined after reset and the block is ready immediately.

Ports:
clk28  input  1  system clock, 28 MHz
rst  input  1  synchronous reset, active-high
active  input  1  ULAplus mode enabled (decoder's active output)
write_req  input  1  palette write strobe; may stay high several consecutive cycles
write_addr  input  6  palette entry to write
write_data  input  8  CPU data byte, GGGRRRBB, valid while write_req=1
pix_valid  input  1  pixel slot strobe from the video pipeline
pix_ink  input  1  1 = ink pixel, 0 = paper pixel
pix_border  input  1  1 = border pixel (attr and pix_ink ignored)
pix_attr  input  8  ZX attribute: [7] flash, [6] bright, [5:3] paper, [2:0] ink
border_color  input  3  border colour (port FE)
busy  output  1  high while the clear sweep runs
rgb_valid  output  1  pix_valid delayed 2 cycles
r  output  3  red
g  output  3  green
b  output  3  blue

Behaviour:
- Reset (rst=1 at a clk28 edge) sets: busy=CLEAR_ON_RESET, rgb_valid=0, r=g=b=0, clear counter=0, pipeline valid bits=0.
- Clear FSM states:
  - IDLE -> CLEAR on reset release when CLEAR_ON_RESET=1.
  - CLEAR writes 8'h00 to entry cnt, then cnt++. After cnt=63 is written: next state IDLE, busy=0. The sweep takes exactly 64 cycles.
  - Writes (write_req) during CLEAR are dropped.
  - Lookups continue during CLEAR but output r=g=b=0; rgb_valid still tracks pix_valid.
  - Reset asserted mid-sweep restarts the sweep from cnt=0.
- Write: in IDLE, write_req=1 stores write_data into entry write_addr on that edge. A held write_req rewrites the same value, which is idempotent.
- Stage 1 (edge after pix_valid), index computation:
  - Border: index = {2'b00, 1'b1, border_color}.
  - Ink: index = {pix_attr[7:6], 1'b0, pix_attr[2:0]}.
  - Paper: index = {pix_attr[7:6], 1'b1, pix_attr[5:3]}.
  - The palette entry is registered. The same stage registers the standard-colour fallback and the active flag.
- Read-during-write: if a write to entry X occurs on the same edge as a stage-1 read of X, stage 1 captures the new write_data (bypass).
- Stage 2 (second edge), output registers:
  - active=1: g = e[7:5], r = e[4:2], b = {e[1], e[0], e[1]|e[0]}.
  - active=0: standard ZX colour. The colour is the border, ink or paper 3-bit GRB code c (c[2]=G, c[1]=R, c[0]=B). Each channel = 3'b000 if its bit is clear, else 3'b111 if bright, else 3'b101. Border is never bright.
  - Flash inversion is done upstream by swapping pix_ink; this block ignores attr[7] in ZX mode.
- active is sampled in stage 1 with the pixel, so a mode change never mixes modes within one pixel.
- rgb_valid=1 exactly 2 cycles after each pix_valid=1, including back-to-back pixels (one pixel per clock throughput). When rgb_valid=0, r/g/b hold their last value.
- The block has no ready/stall signal: it always accepts a pixel.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy high for exactly 64 cycles. After the sweep, active=1 lookup of each index 0..63 returns r=g=b=0. A write_req issued at sweep cycle 10 is lost.
- Write addr 6'd17 data 8'hE3, then active=1, ink pixel attr 8'h41 (bright=1, ink=1) -> 2 cycles later rgb_valid=1, g=3'b111, r=3'b000, b=3'b111.
- Write addr 6'd8 data 8'h1C, then active=1, border pixel with border_color=0 -> r=3'b111, g=0, b=0.
- active=0, paper pixel attr 8'h50 (bright, paper=2 -> red) -> r=3'b111, g=0, b=0. Same with attr 8'h10 -> r=3'b101.
- Write to entry 5 data 8'h02 on the same edge as an active=1 ink lookup of attr 8'h05 -> output uses 8'h02: b=3'b101, r=g=0.
- Five consecutive pix_valid pixels with active toggled mid-burst -> five consecutive rgb_valid cycles. Each pixel is coloured per the active value at its own stage-1 edge. Assert rst mid-burst -> rgb_valid=0 on the next cycle.
